// File: rtl/cjg_phase_gen.sv
// Non-overlapping multi-phase clock generator. Each phase pulses high for
// hi_len cycles and is followed by a gap_len all-low gap; lengths are frozen per period.
module cjg_phase_gen #(
    parameter int unsigned NUM_PHASES = 2,
    parameter int unsigned CFG_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [CFG_W-1:0]      hi_len,
    input  logic [CFG_W-1:0]      gap_len,
    output logic [NUM_PHASES-1:0] clk_ph,
    output logic                  period_start,
    output logic                  running,
    input  logic                  scan_in0,
    input  logic                  scan_en,
    input  logic                  test_mode,
    output logic                  scan_out0
);

    localparam int unsigned IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam logic [NUM_PHASES-1:0] PH_ONE  = NUM_PHASES'(1);
    localparam logic [IDX_W-1:0]      IDX_MAX = IDX_W'(NUM_PHASES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CFG_W-1:0]        cnt_q, cnt_d;
    logic [CFG_W-1:0]        hi_sh_q, hi_sh_d;
    logic [CFG_W-1:0]        gap_sh_q, gap_sh_d;
    logic [NUM_PHASES-1:0]   clk_ph_q, clk_ph_d;
    logic                    period_start_q, period_start_d;
    logic                    running_q, running_d;

    logic [CFG_W-1:0]        hi_last;
    logic [CFG_W-1:0]        gap_last;
    logic [IDX_W-1:0]        idx_inc;
    logic                    phase_done;
    logic                    start_period;

    // Scan chain is stitched in at insertion; until then the hooks are inert.
    logic unused_scan;
    assign unused_scan = scan_in0 ^ scan_en;
    assign scan_out0   = 1'b0;

    assign clk_ph       = clk_ph_q;
    assign period_start = period_start_q;
    assign running      = running_q;

    // Next-state and next-output decode
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        hi_sh_d        = hi_sh_q;
        gap_sh_d       = gap_sh_q;
        clk_ph_d       = clk_ph_q;
        period_start_d = 1'b0;
        running_d      = running_q;
        phase_done     = 1'b0;
        start_period   = 1'b0;
        hi_last        = (hi_sh_q == '0) ? '0 : hi_sh_q - CFG_W'(1);
        gap_last       = gap_sh_q - CFG_W'(1);
        idx_inc        = idx_q + IDX_W'(1);

        case (state_q)
            IDLE: begin
                clk_ph_d  = '0;
                running_d = 1'b0;
                if (enable) begin
                    start_period = 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == hi_last) begin
                    if (gap_sh_q == '0) begin
                        phase_done = 1'b1;
                    end else begin
                        state_d  = GAP;
                        cnt_d    = '0;
                        clk_ph_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CFG_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == gap_last) begin
                    phase_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + CFG_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                idx_d    = '0;
                cnt_d    = '0;
                clk_ph_d = '0;
                running_d = 1'b0;
            end
        endcase

        // Enable is only consulted at the period boundary, so a period always completes.
        if (phase_done) begin
            if (idx_q == IDX_MAX) begin
                if (enable) begin
                    start_period = 1'b1;
                end else begin
                    state_d   = IDLE;
                    idx_d     = '0;
                    cnt_d     = '0;
                    clk_ph_d  = '0;
                    running_d = 1'b0;
                end
            end else begin
                state_d  = HIGH;
                idx_d    = idx_inc;
                cnt_d    = '0;
                clk_ph_d = PH_ONE << idx_inc;
            end
        end

        if (start_period) begin
            state_d        = HIGH;
            idx_d          = '0;
            cnt_d          = '0;
            hi_sh_d        = hi_len;
            gap_sh_d       = gap_len;
            clk_ph_d       = PH_ONE;
            period_start_d = 1'b1;
            running_d      = 1'b1;
        end

        // Scan needs a static state, so test mode parks the FSM.
        if (test_mode) begin
            state_d        = IDLE;
            idx_d          = '0;
            cnt_d          = '0;
            clk_ph_d       = '0;
            period_start_d = 1'b0;
            running_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            cnt_q          <= '0;
            hi_sh_q        <= '0;
            gap_sh_q       <= '0;
            clk_ph_q       <= '0;
            period_start_q <= 1'b0;
            running_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            hi_sh_q        <= hi_sh_d;
            gap_sh_q       <= gap_sh_d;
            clk_ph_q       <= clk_ph_d;
            period_start_q <= period_start_d;
            running_q      <= running_d;
        end
    end

endmodule

// File: doc/cjg_phase_gen.md
CJG_PHASE_GEN -- requirements
Module: cjg_phase_gen

Interface
REQ-001 Parameter: NUM_PHASES, default 2, number of non-overlapping phase clocks (legal 2..8).
REQ-002 Parameter: CFG_W, default 4, width of the high-width and gap configuration inputs.
REQ-003 Port: clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 Port: reset  input  1  system reset, asynchronous, active-low.
REQ-005 Port: enable  input  1  run request; sampled each clk.
REQ-006 Port: hi_len  input  CFG_W  phase-high duration in clk cycles; 0 SHALL be treated as 1.
REQ-007 Port: gap_len  input  CFG_W  all-low gap after each phase pulse, in clk cycles; 0 legal, meaning phases abut but never overlap.
REQ-008 Port: clk_ph  output  NUM_PHASES  phase clocks, one-hot or all-zero, registered.
REQ-009 Port: period_start  output  1  one-cycle pulse, concurrent with the first cycle of clk_ph[0] high.
REQ-010 Port: running  output  1  high while the generator is inside a period.
REQ-011 Ports: scan_in0, scan_en, test_mode  inputs  1 each; scan_out0  output  1; DFT hooks, scan_out0 SHALL be 0 before scan insertion.

Function
REQ-012 Outputs SHALL come straight from flops, with no combinational decode on clk_ph.
REQ-013 At most one clk_ph bit SHALL be high in any cycle.
REQ-014 FSM states SHALL be IDLE, HIGH, GAP.
REQ-015 IDLE -> HIGH (phase 0) SHALL occur on the first edge with enable=1; clk_ph[0] rises one clk after enable is first sampled high.
REQ-016 On entering HIGH, the block SHALL latch hi_len and gap_len into shadow registers only when the phase index is 0.
REQ-017 The shadow values SHALL stay frozen for the whole period, so config changes mid-period SHALL take effect at the next period_start.
REQ-018 HIGH SHALL last shadow hi_len cycles, driving clk_ph[idx]=1; it then goes to GAP, or to the next HIGH if shadow gap_len=0.
REQ-019 GAP SHALL last shadow gap_len cycles with clk_ph all 0.
REQ-020 When GAP ends, idx SHALL advance; on wrap from NUM_PHASES-1 to 0 the FSM SHALL re-enter HIGH if enable=1, else go to IDLE.
REQ-021 Period SHALL equal NUM_PHASES*(max(hi_len,1)+gap_len) cycles.
REQ-022 Deasserting enable mid-period SHALL NOT truncate the period: all remaining phases complete, then IDLE, with no partial pulse.
REQ-023 Reasserting enable before the period ends SHALL continue seamlessly with no idle cycle.
REQ-024 running SHALL be 1 in HIGH and GAP, and 0 in IDLE.
REQ-025 The cycle counter SHALL be CFG_W bits, compare against shadow length minus 1, and never wrap past the shadow length.
REQ-026 In test_mode=1 the FSM SHALL be held in IDLE with clk_ph=0, so scan sees a static state.

Reset
REQ-027 While reset=0: state=IDLE, idx=0, counters=0, shadows=0, and clk_ph, period_start, running all 0, asynchronously.
REQ-028 Reset asserted mid-pulse SHALL drop clk_ph to 0 immediately, and no partial period SHALL resume after release.
REQ-029 After release, the first pulse SHALL require enable sampled high on a clk edge.

Verification
REQ-030 NUM_PHASES=2, hi_len=1, gap_len=1, enable held 1 from reset release -> ph0 high cycle 1, ph1 high cycle 3, period 4, repeating.
REQ-031 NUM_PHASES=4, hi_len=2, gap_len=0 -> 8-cycle period, each phase high 2 cycles back-to-back, never two bits high together.
REQ-032 hi_len changed 1->3 during phase 1 -> current period unchanged; new width starts at next period_start.
REQ-033 enable dropped during ph0 (NUM_PHASES=3, hi_len=1, gap_len=1) -> ph1 and ph2 still fire, then running=0 and clk_ph=0 for as long as enable stays low.
REQ-034 reset pulsed low during ph1 high -> clk_ph=0 same cycle; after release with enable=1, the sequence restarts at ph0 with period_start.
REQ-035 hi_len=0, gap_len=0, NUM_PHASES=2 -> treated as width 1, period 2, one-hot alternating ph0/ph1.
